kl10_edp_datapath: RTL and testbench



---
 rtl/kl10_edp_datapath.sv | 165 ++++++++++++++++
 tb/tb_kl10_edp_datapath.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kl10_edp_datapath.sv
// KL10 EBOX data path slice: AR/ARX/BR/BRX/MQ registers,
// ADA/ADB operand selection and the 38-bit AD adder/logic unit.
module kl10_edp_datapath #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cache_data,
    input  logic [WIDTH-1:0] ebus_in,
    input  logic [WIDTH-1:0] sh,
    input  logic [3:0]       ad_fn,
    input  logic [1:0]       ada_sel,
    input  logic [1:0]       adb_sel,
    input  logic [2:0]       ar_sel,
    input  logic             ar00_08_load,
    input  logic             ar09_17_load,
    input  logic             arr_load,
    input  logic             ar00_11_clr,
    input  logic             ar12_17_clr,
    input  logic             arr_clr,
    input  logic [1:0]       arx_sel,
    input  logic             arx_load,
    input  logic             br_sel,
    input  logic             brx_sel,
    input  logic [1:0]       mq_sel,
    input  logic             mq_en,
    input  logic             inh_cry_18,
    input  logic             spec_gen_cry_18,
    input  logic             ad_to_ebus_l,
    input  logic             ad_to_ebus_r,
    output logic [WIDTH-1:0] ar,
    output logic [WIDTH-1:0] arx,
    output logic [WIDTH-1:0] br,
    output logic [WIDTH-1:0] brx,
    output logic [WIDTH-1:0] mq,
    output logic [WIDTH+1:0] ad,
    output logic             ad_cry_out,
    output logic [WIDTH-1:0] ebus_out
);

    logic [35:0] a36, b36;
    logic [37:0] a_op, b_op;
    logic [37:0] x_op, y_op, lg_res;
    logic        arith, cin0, cin_l;
    logic [18:0] sum_r;
    logic [20:0] sum_l;
    logic [35:0] ar_src, ar_nx, arx_nx, mq_nx;
    logic [35:0] ld_mask, clr_mask;

    // Operand selection; shifts happen before sign extension
    always_comb begin
        a36 = '0;
        b36 = '0;
        unique case (ada_sel)
            2'd0: a36 = ar;
            2'd1: a36 = arx;
            2'd2: a36 = mq;
            2'd3: a36 = '0;
        endcase
        unique case (adb_sel)
            2'd0: b36 = br;
            2'd1: b36 = {br[34:0], 1'b0};
            2'd2: b36 = {ar[33:0], 2'b00};
            2'd3: b36 = '0;
        endcase
        a_op = {{2{a36[35]}}, a36};
        b_op = {{2{b36[35]}}, b36};
    end

    // AD function decode into adder operands or a logic result
    always_comb begin
        arith  = 1'b1;
        x_op   = a_op;
        y_op   = '0;
        cin0   = 1'b0;
        lg_res = '0;
        unique case (ad_fn)
            4'd0:  begin arith = 1'b0; lg_res = a_op; end
            4'd1:  begin arith = 1'b0; lg_res = b_op; end
            4'd2:  y_op = b_op;
            4'd3:  cin0 = 1'b1;
            4'd4:  y_op = a_op;
            4'd5:  begin y_op = ~b_op; cin0 = 1'b1; end
            4'd6:  begin x_op = a_op | ~b_op; cin0 = 1'b1; end
            4'd7:  begin arith = 1'b0; lg_res = a_op & b_op; end
            4'd8:  begin arith = 1'b0; lg_res = a_op | b_op; end
            4'd9:  begin arith = 1'b0; lg_res = a_op ^ b_op; end
            4'd10: begin arith = 1'b0; lg_res = ~a_op; end
            4'd11: y_op = '1;
            4'd12: begin arith = 1'b0; lg_res = '0; end
            4'd13: begin arith = 1'b0; lg_res = '1; end
            4'd14: begin y_op = b_op; cin0 = 1'b1; end
            4'd15: begin x_op = b_op; cin0 = 1'b1; end
        endcase
    end

    // Two chained half adders with controllable carry into bit 17
    always_comb begin
        sum_r = {1'b0, x_op[17:0]} + {1'b0, y_op[17:0]}
              + {18'b0, cin0};
        cin_l = spec_gen_cry_18 | (~inh_cry_18 & sum_r[18]);
        sum_l = {1'b0, x_op[37:18]} + {1'b0, y_op[37:18]}
              + {20'b0, cin_l};
        ad         = arith ? {sum_l[19:0], sum_r[17:0]} : lg_res;
        ad_cry_out = arith & sum_l[20];
        ebus_out   = {ad_to_ebus_l ? ad[35:18] : 18'b0,
                      ad_to_ebus_r ? ad[17:0]  : 18'b0};
    end

    // Next-state selection for AR, ARX and MQ
    always_comb begin
        ar_src = '0;
        arx_nx = arx;
        mq_nx  = mq;
        unique case (ar_sel)
            3'd0: ar_src = ar;
            3'd1: ar_src = cache_data;
            3'd2: ar_src = ad[35:0];
            3'd3: ar_src = ebus_in;
            3'd4: ar_src = sh;
            3'd5: ar_src = {ad[34:0], 1'b0};
            3'd6: ar_src = ad[37:2];
            3'd7: ar_src = '0;
        endcase
        ld_mask  = {{9{ar00_08_load}}, {9{ar09_17_load}},
                    {18{arr_load}}};
        clr_mask = {{12{ar00_11_clr}}, {6{ar12_17_clr}},
                    {18{arr_clr}}};
        ar_nx = ((ar & ~ld_mask) | (ar_src & ld_mask)) & ~clr_mask;
        if (arx_load) begin
            unique case (arx_sel)
                2'd0: arx_nx = arx;
                2'd1: arx_nx = cache_data;
                2'd2: arx_nx = ad[35:0];
                2'd3: arx_nx = mq;
            endcase
        end
        if (mq_en) begin
            unique case (mq_sel)
                2'd0: mq_nx = mq;
                2'd1: mq_nx = ad[35:0];
                2'd2: mq_nx = {mq[34:0], 1'b0};
                2'd3: mq_nx = '0;
            endcase
        end
    end

    // Register file update; reset overrides every load and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ar  <= '0;
            arx <= '0;
            br  <= '0;
            brx <= '0;
            mq  <= '0;
        end else begin
            ar  <= ar_nx;
            arx <= arx_nx;
            br  <= br_sel ? ar : br;
            brx <= brx_sel ? arx : brx;
            mq  <= mq_nx;
        end
    end

endmodule

// File: tb/tb_kl10_edp_datapath.sv
// Bench for kl10_edp_datapath: directed vector table plus
// random traffic checked against a behavioural model.
module tb_kl10_edp_datapath;

    typedef struct packed {
        logic [3:0] fn;
        logic [1:0] ada;
        logic [1:0] adb;
        logic [2:0] ar_sel;
        logic [2:0] ar_ld;
        logic [2:0] ar_clr;
        logic [1:0] arx_sel;
        logic       arx_ld;
        logic       br_sel;
        logic       brx_sel;
        logic [1:0] mq_sel;
        logic       mq_en;
        logic       inh;
        logic       spec;
        logic       ebl;
        logic       ebr;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [35:0] cache;
        logic [37:0] exp_ad;
        logic        exp_cry;
        logic [35:0] exp_ebus;
        logic [35:0] exp_ar;
        logic [35:0] exp_br;
    } vec_t;

    localparam longint M38 = 64'h3F_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    ctl_t        cur;
    logic [35:0] cache_data, ebus_in, sh;
    logic [35:0] ar, arx, br, brx, mq, ebus_out;
    logic [37:0] ad;
    logic        ad_cry_out;

    logic [35:0] m_ar, m_arx, m_br, m_brx, m_mq;
    int checks = 0;
    int errors = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    kl10_edp_datapath dut (
        .clk(clk), .reset(reset),
        .cache_data(cache_data), .ebus_in(ebus_in), .sh(sh),
        .ad_fn(cur.fn), .ada_sel(cur.ada), .adb_sel(cur.adb),
        .ar_sel(cur.ar_sel),
        .ar00_08_load(cur.ar_ld[2]), .ar09_17_load(cur.ar_ld[1]),
        .arr_load(cur.ar_ld[0]),
        .ar00_11_clr(cur.ar_clr[2]), .ar12_17_clr(cur.ar_clr[1]),
        .arr_clr(cur.ar_clr[0]),
        .arx_sel(cur.arx_sel), .arx_load(cur.arx_ld),
        .br_sel(cur.br_sel), .brx_sel(cur.brx_sel),
        .mq_sel(cur.mq_sel), .mq_en(cur.mq_en),
        .inh_cry_18(cur.inh), .spec_gen_cry_18(cur.spec),
        .ad_to_ebus_l(cur.ebl), .ad_to_ebus_r(cur.ebr),
        .ar(ar), .arx(arx), .br(br), .brx(brx), .mq(mq),
        .ad(ad), .ad_cry_out(ad_cry_out), .ebus_out(ebus_out)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference AD: integer arithmetic on 38-bit values, split at 18
    function automatic logic [38:0] model_ad(ctl_t k);
        logic [35:0] av, bv;
        logic [37:0] a, b, res;
        longint x, y, c, r, l, cl;
        logic arith, cout;
        case (k.ada)
            2'd0: av = m_ar;
            2'd1: av = m_arx;
            2'd2: av = m_mq;
            default: av = '0;
        endcase
        case (k.adb)
            2'd0: bv = m_br;
            2'd1: bv = m_br << 1;
            2'd2: bv = m_ar << 2;
            default: bv = '0;
        endcase
        a = {{2{av[35]}}, av};
        b = {{2{bv[35]}}, bv};
        arith = 1'b1;
        x = longint'(a);
        y = 0;
        c = 0;
        res = '0;
        cout = 1'b0;
        case (k.fn)
            4'd0:  begin arith = 1'b0; res = a; end
            4'd1:  begin arith = 1'b0; res = b; end
            4'd2:  y = longint'(b);
            4'd3:  c = 1;
            4'd4:  y = longint'(a);
            4'd5:  begin y = M38 - longint'(b); c = 1; end
            4'd6:  begin x = longint'(a) | (M38 - longint'(b)); c = 1; end
            4'd7:  begin arith = 1'b0; res = a & b; end
            4'd8:  begin arith = 1'b0; res = a | b; end
            4'd9:  begin arith = 1'b0; res = a ^ b; end
            4'd10: begin arith = 1'b0; res = ~a; end
            4'd11: y = M38;
            4'd12: begin arith = 1'b0; res = '0; end
            4'd13: begin arith = 1'b0; res = '1; end
            4'd14: begin y = longint'(b); c = 1; end
            default: begin x = longint'(b); c = 1; end
        endcase
        if (arith) begin
            r = (x & 'h3FFFF) + (y & 'h3FFFF) + c;
            if (k.spec) cl = 1;
            else if (k.inh) cl = 0;
            else cl = r >> 18;
            l = (x >> 18) + (y >> 18) + cl;
            res = 38'(((l & 'hFFFFF) << 18) | (r & 'h3FFFF));
            cout = l[20];
        end
        return {cout, res};
    endfunction

    task automatic check_all(input string tag);
        logic [38:0] e;
        logic [35:0] eb;
        e = model_ad(cur);
        eb = 36'(e[35:0]);
        if (!cur.ebl) eb = eb & 36'h0_0003_FFFF;
        if (!cur.ebr) eb = eb & 36'hF_FFFC_0000;
        chk({tag, ".ar"}, 64'(ar), 64'(m_ar));
        chk({tag, ".arx"}, 64'(arx), 64'(m_arx));
        chk({tag, ".br"}, 64'(br), 64'(m_br));
        chk({tag, ".brx"}, 64'(brx), 64'(m_brx));
        chk({tag, ".mq"}, 64'(mq), 64'(m_mq));
        chk({tag, ".ad"}, 64'(ad), 64'(e[37:0]));
        chk({tag, ".cry"}, 64'(ad_cry_out), 64'(e[38]));
        chk({tag, ".ebus"}, 64'(ebus_out), 64'(eb));
    endtask

    // Advance one clock, updating the model from pre-edge state
    task automatic tick();
        logic [38:0] e;
        logic [35:0] src, n_ar, n_arx, n_br, n_brx, n_mq;
        logic [37:0] adv;
        bit clr, ld;
        int b;
        e = model_ad(cur);
        adv = e[37:0];
        case (cur.ar_sel)
            3'd0: src = m_ar;
            3'd1: src = cache_data;
            3'd2: src = adv[35:0];
            3'd3: src = ebus_in;
            3'd4: src = sh;
            3'd5: src = 36'(adv << 1);
            3'd6: src = 36'(adv >> 2);
            default: src = '0;
        endcase
        for (int d = 0; d < 36; d++) begin
            b = 35 - d;
            clr = (d < 12 && cur.ar_clr[2]) ||
                  (d >= 12 && d < 18 && cur.ar_clr[1]) ||
                  (d >= 18 && cur.ar_clr[0]);
            ld = (d < 9 && cur.ar_ld[2]) ||
                 (d >= 9 && d < 18 && cur.ar_ld[1]) ||
                 (d >= 18 && cur.ar_ld[0]);
            n_ar[b] = clr ? 1'b0 : (ld ? src[b] : m_ar[b]);
        end
        n_arx = m_arx;
        if (cur.arx_ld)
            case (cur.arx_sel)
                2'd1: n_arx = cache_data;
                2'd2: n_arx = adv[35:0];
                2'd3: n_arx = m_mq;
                default: n_arx = m_arx;
            endcase
        n_br = cur.br_sel ? m_ar : m_br;
        n_brx = cur.brx_sel ? m_arx : m_brx;
        n_mq = m_mq;
        if (cur.mq_en)
            case (cur.mq_sel)
                2'd1: n_mq = adv[35:0];
                2'd2: n_mq = m_mq << 1;
                2'd3: n_mq = '0;
                default: n_mq = m_mq;
            endcase
        if (reset) begin
            n_ar = '0; n_arx = '0; n_br = '0; n_brx = '0; n_mq = '0;
        end
        @(posedge clk);
        #1;
        m_ar = n_ar; m_arx = n_arx; m_br = n_br;
        m_brx = n_brx; m_mq = n_mq;
    endtask

    task automatic add(input ctl_t c, input logic [35:0] cd,
                       input logic [37:0] ead, input logic ecry,
                       input logic [35:0] eeb, input logic [35:0] ear,
                       input logic [35:0] ebr);
        vec_t v;
        v.c = c; v.cache = cd; v.exp_ad = ead; v.exp_cry = ecry;
        v.exp_ebus = eeb; v.exp_ar = ear; v.exp_br = ebr;
        tv.push_back(v);
    endtask

    initial begin
        ctl_t k;
        logic [31:0] rv;
        localparam logic [35:0] O7 = 36'o007757777;
        localparam logic [35:0] P = 36'h987654321;
        localparam logic [35:0] Q = 36'h123456789;

        k = '0;
        add(k, 0, 0, 0, 0, 0, 0);
        k = '0; k.ar_sel = 1; k.ar_ld = 3'b111;
        add(k, 36'h555555555, 0, 0, 0, 36'h555555555, 0);
        k = '0;
        add(k, 0, 38'h0555555555, 0, 0, 36'h555555555, 0);
        k = '0; k.ar_sel = 1; k.ar_ld = 3'b111;
        add(k, P, 38'h0555555555, 0, 0, P, 0);
        k = '0; k.ar_sel = 1; k.ar_ld = 3'b111; k.br_sel = 1; k.fn = 1;
        add(k, Q, 0, 0, 0, Q, P);
        k = '0; k.fn = 1; k.ebl = 1; k.ebr = 1;
        add(k, 0, 38'h3987654321, 0, P, Q, P);
        k = '0; k.fn = 2;
        add(k, 0, 38'h3AAAAAAAAA, 0, 0, Q, P);
        k = '0; k.fn = 4;
        add(k, 0, 38'h02468ACF12, 0, 0, Q, P);
        k = '0; k.fn = 4; k.ar_sel = 1; k.ar_ld = 3'b111;
        add(k, O7, 38'h02468ACF12, 0, 0, O7, P);
        k = '0; k.br_sel = 1;
        add(k, 0, 38'h00001FDFFF, 0, 0, O7, O7);
        k = '0; k.fn = 6; k.ebl = 1; k.ebr = 1;
        add(k, 0, 0, 1, 0, O7, O7);
        k = '0; k.fn = 3; k.ar_sel = 1; k.ar_ld = 3'b111;
        add(k, 36'hFFFFFFFFF, 38'h00001FE000, 0, 0, 36'hFFFFFFFFF, O7);
        k = '0; k.fn = 3;
        add(k, 0, 0, 1, 0, 36'hFFFFFFFFF, O7);
        k = '0; k.fn = 3; k.inh = 1; k.ebl = 1;
        add(k, 0, 38'h3FFFFC0000, 0, 36'hFFFFC0000, 36'hFFFFFFFFF, O7);
        k = '0; k.fn = 3; k.inh = 1; k.spec = 1;
        add(k, 0, 0, 1, 0, 36'hFFFFFFFFF, O7);
        k = '0; k.ar_sel = 1; k.ar_ld = 3'b100; k.ar_clr = 3'b100;
        k.ebr = 1;
        add(k, Q, 38'h3FFFFFFFFF, 0, 36'h00003FFFF, 36'h000FFFFFF, O7);
        k = '0; k.ar_sel = 1; k.ar_ld = 3'b010; k.ar_clr = 3'b010;
        k.ebr = 1;
        add(k, Q, 38'h0000FFFFFF, 0, 36'h00003FFFF, 36'h00303FFFF, O7);
        k = '0; k.ebl = 1; k.ebr = 1;
        add(k, 0, 38'h000303FFFF, 0, 36'h00303FFFF, 36'h00303FFFF, O7);
        k = '0; k.fn = 1; k.adb = 1;
        add(k, 0, 38'h00003FBFFE, 0, 0, 36'h00303FFFF, O7);
        k = '0; k.fn = 1; k.adb = 2;
        add(k, 0, 38'h000C0FFFFC, 0, 0, 36'h00303FFFF, O7);

        cur = '0;
        cache_data = '0; ebus_in = '0; sh = '0;
        m_ar = '0; m_arx = '0; m_br = '0; m_brx = '0; m_mq = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check_all("idle");

        foreach (tv[i]) begin
            cur = tv[i].c;
            cache_data = tv[i].cache;
            @(negedge clk);
            chk($sformatf("tv%0d.ad", i), 64'(ad), 64'(tv[i].exp_ad));
            chk($sformatf("tv%0d.cry", i), 64'(ad_cry_out),
                64'(tv[i].exp_cry));
            chk($sformatf("tv%0d.ebus", i), 64'(ebus_out),
                64'(tv[i].exp_ebus));
            check_all($sformatf("tv%0d", i));
            tick();
            chk($sformatf("tv%0d.ar_nx", i), 64'(ar), 64'(tv[i].exp_ar));
            chk($sformatf("tv%0d.br_nx", i), 64'(br), 64'(tv[i].exp_br));
        end

        for (int i = 0; i < 600; i++) begin
            rv = $urandom;
            cur = ctl_t'(rv[28:0]);
            if ($urandom_range(3) != 0) cur.ar_clr = '0;
            cache_data = {$urandom, $urandom};
            ebus_in = {$urandom, $urandom};
            sh = {$urandom, $urandom};
            reset = ($urandom_range(60) == 0);
            @(negedge clk);
            check_all($sformatf("rnd%0d", i));
            tick();
        end

        cur = '0;
        cur.ar_sel = 1; cur.ar_ld = 3'b111; cur.arx_ld = 1;
        cur.arx_sel = 1; cur.br_sel = 1; cur.brx_sel = 1;
        cur.mq_en = 1; cur.mq_sel = 1;
        cache_data = 36'hFFFFFFFFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur = '0;
        @(negedge clk);
        chk("rst.ar", 64'(ar), 0);
        chk("rst.arx", 64'(arx), 0);
        chk("rst.br", 64'(br), 0);
        chk("rst.brx", 64'(brx), 0);
        chk("rst.mq", 64'(mq), 0);
        check_all("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
